// File: rtl/mem_initiator_if.sv
// CPU-side burst request/stream signals plus the single-port memory bus of mem_initiator.
// master = initiator view; slave = CPU/memory environment view.
interface mem_initiator_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, mem_rdata,
    output req_ready, wdata_ready, rdata_valid, rdata, busy, done,
           MemRead, MemWrite, ADDR, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, mem_rdata,
    input  req_ready, wdata_ready, rdata_valid, rdata, busy, done,
           MemRead, MemWrite, ADDR, mem_wdata
  );
endinterface

// File: rtl/mem_initiator.sv
// Burst memory initiator: one write per accepted wdata beat, one read issue per cycle, read data out 2 cycles after MemRead.
// Write stream backpressured by state (ready only in WRITE); read stream has no backpressure; requests only taken in IDLE.
module mem_initiator #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic          CLK,
  input  logic          reset,
  mem_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              done_q, done_d;
  logic              last_iss_q, last_iss_d;
  // ret_q marks the cycle mem_rdata is valid; last_ret_q marks it for the final word of a burst
  logic              ret_q, last_ret_q;

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    rem_d         = rem_q;
    addr_d        = addr_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    last_iss_d    = 1'b0;
    done_d        = 1'b0;
    rdata_valid_d = ret_q;
    rdata_d       = ret_q ? bus.mem_rdata : rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cur_addr_d = bus.req_addr;
          rem_d      = bus.req_len;
          state_d    = bus.req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (bus.wdata_valid) begin
          mem_write_d = 1'b1;
          addr_d      = cur_addr_q;
          mem_wdata_d = bus.wdata;
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      READ: begin
        mem_read_d = 1'b1;
        addr_d     = cur_addr_q;
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        if (rem_q == '0) begin
          state_d    = DRAIN;
          last_iss_d = 1'b1;
        end else begin
          rem_d = rem_q - LEN_W'(1);
        end
      end
      DRAIN: begin
        if (last_ret_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      rem_q         <= '0;
      addr_q        <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      last_iss_q    <= 1'b0;
      ret_q         <= 1'b0;
      last_ret_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      rem_q         <= rem_d;
      addr_q        <= addr_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      last_iss_q    <= last_iss_d;
      ret_q         <= mem_read_q;
      last_ret_q    <= last_iss_q;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.wdata_ready = (state_q == WRITE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.MemRead     = mem_read_q;
  assign bus.MemWrite    = mem_write_q;
  assign bus.ADDR        = addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a registered-read behavioural memory and a negedge bus logger.
module tb_mem_initiator;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  mem_initiator_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(4)) bus();
  mem_initiator dut (.CLK(CLK), .reset(reset), .bus(bus));

  logic [15:0] mem [0:65535];
  always @(posedge CLK) begin
    if (bus.MemWrite) mem[bus.ADDR] <= bus.mem_wdata;
    if (bus.MemRead) bus.mem_rdata <= mem[bus.ADDR];
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int both_hi = 0;
  int wr_addr[$], wr_dat[$], wr_cyc[$];
  int rd_addr[$], rd_cyc[$];
  int rv_dat[$], rv_cyc[$];
  int done_cyc[$];

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (bus.MemRead && bus.MemWrite) both_hi <= both_hi + 1;
    if (bus.MemWrite) begin
      wr_addr.push_back(int'(bus.ADDR));
      wr_dat.push_back(int'(bus.mem_wdata));
      wr_cyc.push_back(cyc);
    end
    if (bus.MemRead) begin
      rd_addr.push_back(int'(bus.ADDR));
      rd_cyc.push_back(cyc);
    end
    if (bus.rdata_valid) begin
      rv_dat.push_back(int'(bus.rdata));
      rv_cyc.push_back(cyc);
    end
    if (bus.done) done_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    wr_addr.delete(); wr_dat.delete(); wr_cyc.delete();
    rd_addr.delete(); rd_cyc.delete();
    rv_dat.delete(); rv_cyc.delete();
    done_cyc.delete();
  endtask

  // All tasks start and end just after a rising edge.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [3:0] l);
    bit ok = 0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_len = l;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge CLK);
      if (bus.req_ready) ok = 1;
      @(posedge CLK); #1;
    end
    bus.req_valid = 1'b0;
    if (!ok) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [15:0] d);
    bit ok = 0;
    bus.wdata = d; bus.wdata_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge CLK);
      if (bus.wdata_ready) ok = 1;
      @(posedge CLK); #1;
    end
    bus.wdata_valid = 1'b0;
    if (!ok) chk("wdata_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit got = 0;
    for (int n = 0; n < bound && !got; n++) begin
      @(negedge CLK);
      if (bus.done) got = 1;
      @(posedge CLK); #1;
    end
    if (!got) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic check_read(input string tag, input int n, input int a0, input int exp_d[$]);
    chk({tag, "_nread"}, rd_addr.size(), n);
    chk({tag, "_nstrobe"}, rv_dat.size(), n);
    chk({tag, "_ndone"}, done_cyc.size(), 1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), at(rd_addr, i), (a0 + i) & 32'hFFFF);
      chk($sformatf("%s_data%0d", tag, i), at(rv_dat, i), exp_d[i]);
    end
    chk({tag, "_consecutive"}, at(rd_cyc, n - 1) - at(rd_cyc, 0), n - 1);
    chk({tag, "_first_lat"}, at(rv_cyc, 0) - at(rd_cyc, 0), 2);
    chk({tag, "_done_with_last"}, at(done_cyc, 0), at(rv_cyc, n - 1));
  endtask

  initial begin
    int exp_d[$];
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wdata_valid = 1'b0; bus.wdata = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_memread", bus.MemRead, 0);
    chk("rst_memwrite", bus.MemWrite, 0);
    chk("rst_addr", bus.ADDR, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rdata_valid", bus.rdata_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_wdata_ready", bus.wdata_ready, 0);
    @(posedge CLK); #1;
    reset = 1'b1;

    // single write
    do_req(1'b1, 16'h0003, 4'd0);
    @(negedge CLK);
    chk("w1_wdata_ready", bus.wdata_ready, 1);
    chk("w1_busy", bus.busy, 1);
    chk("w1_no_early_write", bus.MemWrite, 0);
    @(posedge CLK); #1;
    send_word(16'hBEEF);
    @(negedge CLK);
    chk("w1_memwrite", bus.MemWrite, 1);
    chk("w1_addr", bus.ADDR, 16'h0003);
    chk("w1_mem_wdata", bus.mem_wdata, 16'hBEEF);
    chk("w1_done", bus.done, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("w1_busy_fall", bus.busy, 0);
    chk("w1_done_pulse", bus.done, 0);
    chk("w1_memwrite_low", bus.MemWrite, 0);
    chk("w1_wdata_hold", bus.mem_wdata, 16'hBEEF);
    @(posedge CLK); #1;

    // burst write with wdata_valid toggling
    clear_logs();
    do_req(1'b1, 16'h0004, 4'd3);
    for (int i = 1; i <= 4; i++) begin
      send_word(16'(16'h1111 * i));
      idle(1);
    end
    idle(3);
    chk("bw_nwrite", wr_addr.size(), 4);
    chk("bw_ndone", done_cyc.size(), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bw_addr%0d", i), at(wr_addr, i), 4 + i);
      chk($sformatf("bw_data%0d", i), at(wr_dat, i), 16'h1111 * (i + 1));
    end
    chk("bw_done_with_last", at(done_cyc, 0), at(wr_cyc, 3));

    // read back
    clear_logs();
    do_req(1'b0, 16'h0004, 4'd3);
    wait_done("br", 20);
    idle(3);
    exp_d = '{32'h1111, 32'h2222, 32'h3333, 32'h4444};
    check_read("br", 4, 4, exp_d);

    // address wrap
    clear_logs();
    do_req(1'b0, 16'hFFFF, 4'd2);
    wait_done("wrap", 20);
    idle(3);
    exp_d = '{32'h5A5A, 32'hA5A5, 32'hA5A4};
    check_read("wrap", 3, 32'hFFFF, exp_d);

    // maximum burst length
    clear_logs();
    do_req(1'b0, 16'h0000, 4'd15);
    wait_done("max", 40);
    idle(3);
    exp_d.delete();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) exp_d.push_back(32'hBEEF);
      else if (i >= 4 && i <= 7) exp_d.push_back(32'h1111 * (i - 3));
      else exp_d.push_back(int'(16'(i) ^ 16'hA5A5));
    end
    check_read("max", 16, 0, exp_d);

    // reset in the middle of a read burst
    clear_logs();
    do_req(1'b0, 16'h0020, 4'd7);
    begin
      bit seen = 0;
      int nrd = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge CLK);
        if (bus.MemRead) nrd++;
        if (nrd == 2) seen = 1;
        else begin @(posedge CLK); #1; end
      end
      chk("mr_second_read_seen", seen, 1);
    end
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    chk("mr_memread", bus.MemRead, 0);
    chk("mr_memwrite", bus.MemWrite, 0);
    chk("mr_addr", bus.ADDR, 0);
    chk("mr_mem_wdata", bus.mem_wdata, 0);
    chk("mr_rdata", bus.rdata, 0);
    chk("mr_rdata_valid", bus.rdata_valid, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_req_ready", bus.req_ready, 1);
    clear_logs();
    @(posedge CLK); #1;
    idle(8);
    chk("mr_no_strobe", rv_dat.size(), 0);
    chk("mr_no_done", done_cyc.size(), 0);
    chk("mr_no_read", rd_addr.size(), 0);

    // request held while busy must be ignored
    clear_logs();
    do_req(1'b1, 16'h0040, 4'd1);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h0080; bus.req_len = 4'd0;
    idle(2);
    @(negedge CLK);
    chk("bz_busy", bus.busy, 1);
    chk("bz_req_ready", bus.req_ready, 0);
    @(posedge CLK); #1;
    send_word(16'h5555);
    send_word(16'h6666);
    bus.req_valid = 1'b0;
    idle(6);
    chk("bz_nwrite", wr_addr.size(), 2);
    chk("bz_addr0", at(wr_addr, 0), 16'h0040);
    chk("bz_addr1", at(wr_addr, 1), 16'h0041);
    chk("bz_data1", at(wr_dat, 1), 16'h6666);
    chk("bz_ndone", done_cyc.size(), 1);
    @(negedge CLK);
    chk("bz_idle", bus.busy, 0);

    chk("never_both_enables", both_hi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
